// File: rtl/student_fir_pkg.sv
`default_nettype none
// ============================================================================
// Package     : student_fir_pkg
// Description : Shared definitions for the student FIR datapath. Holds the
//               sample-sequencer FSM state encoding and the default sample
//               memory geometry used by the sequencer and its DPRAM.
// Revision    : 1.0 - initial release
// ============================================================================
package student_fir_pkg;

  // Default sample-memory geometry
  localparam int c_ADDR_WIDTH = 10;
  localparam int c_DATA_SIZE  = 16;

  // Sequencer FSM: accept a sample, sweep the taps, one settle cycle
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

endpackage : student_fir_pkg
`default_nettype wire

// File: rtl/student_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : student_sample_sequencer
// Description : Accepts one input sample per handshake, writes it into the
//               circular sample DPRAM, then reads NumTaps samples back,
//               newest first, streaming them to the MAC stage with tap index
//               and first/last markers.
// Ports       : clk_i, rst_i                     - clock, sync active-high reset
//               sample_i/_valid_i/_ready_o        - sample input handshake
//               ram_ena_o/wea_o/addra_o/dia_o     - DPRAM write port
//               ram_enb_o/addrb_o, ram_dob_i      - DPRAM read port (1-cycle)
//               mac_valid_o/sample_o/tap_o/
//               first_o/last_o                    - stream to MAC stage
//               busy_o                            - high when not idle
// Revision    : 1.0 - initial release
// ============================================================================
module student_sample_sequencer
  import student_fir_pkg::*;
#(
  parameter int AddrWidth = c_ADDR_WIDTH,
  parameter int DataSize  = c_DATA_SIZE,
  parameter int NumTaps   = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DataSize-1:0]  sample_i,
  input  logic                 sample_valid_i,
  output logic                 sample_ready_o,
  output logic                 ram_ena_o,
  output logic                 ram_wea_o,
  output logic [AddrWidth-1:0] ram_addra_o,
  output logic [DataSize-1:0]  ram_dia_o,
  output logic                 ram_enb_o,
  output logic [AddrWidth-1:0] ram_addrb_o,
  input  logic [DataSize-1:0]  ram_dob_i,
  output logic                 mac_valid_o,
  output logic [DataSize-1:0]  mac_sample_o,
  output logic [AddrWidth-1:0] mac_tap_o,
  output logic                 mac_first_o,
  output logic                 mac_last_o,
  output logic                 busy_o
);

  // NumTaps may equal 2**AddrWidth, so the last tap index still fits.
  localparam logic [AddrWidth-1:0] c_LAST_TAP = AddrWidth'(NumTaps - 1);

  seq_state_e           state_q, state_d;
  logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrWidth-1:0] base_q, base_d;
  logic [AddrWidth-1:0] tap_q, tap_d;

  // Single-stage issue pipeline aligned with the 1-cycle RAM read latency
  logic                 mac_valid_q, mac_valid_d;
  logic [AddrWidth-1:0] mac_tap_q, mac_tap_d;
  logic                 mac_first_q, mac_first_d;
  logic                 mac_last_q, mac_last_d;

  logic accept;
  logic issue;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    base_d      = base_q;
    tap_d       = tap_q;
    mac_valid_d = 1'b0;
    mac_tap_d   = mac_tap_q;
    mac_first_d = 1'b0;
    mac_last_d  = 1'b0;
    accept      = 1'b0;
    issue       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sample_valid_i && !rst_i) begin
          accept  = 1'b1;
          base_d  = wr_ptr_q;
          tap_d   = '0;
          state_d = ST_READ;
        end
      end

      ST_READ: begin
        issue       = !rst_i;
        mac_valid_d = 1'b1;
        mac_tap_d   = tap_q;
        mac_first_d = (tap_q == '0);
        mac_last_d  = (tap_q == c_LAST_TAP);
        tap_d       = tap_q + AddrWidth'(1);
        if (tap_q == c_LAST_TAP) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        // The pointer only moves once the whole burst has been issued, so an
        // aborted burst leaves it untouched.
        wr_ptr_d = wr_ptr_q + AddrWidth'(1);
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      base_q      <= '0;
      tap_q       <= '0;
      mac_valid_q <= 1'b0;
      mac_tap_q   <= '0;
      mac_first_q <= 1'b0;
      mac_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      base_q      <= base_d;
      tap_q       <= tap_d;
      mac_valid_q <= mac_valid_d;
      mac_tap_q   <= mac_tap_d;
      mac_first_q <= mac_first_d;
      mac_last_q  <= mac_last_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Everything is forced quiet while reset is held, including the
  // first reset cycle before the registers have been cleared.
  // --------------------------------------------------------------------------
  always_comb begin
    sample_ready_o = (state_q == ST_IDLE) && !rst_i;
    busy_o         = (state_q != ST_IDLE) && !rst_i;

    // Write port: the accepted sample lands at wr_ptr in the handshake cycle.
    ram_ena_o      = accept;
    ram_wea_o      = accept;
    ram_addra_o    = wr_ptr_q;
    ram_dia_o      = accept ? sample_i : '0;

    // Read port: tap 0 is the newest sample, older samples sit below base.
    ram_enb_o      = issue;
    ram_addrb_o    = base_q - tap_q;

    // RAM data arrives one cycle after issue, alongside the piped tap info.
    mac_valid_o    = mac_valid_q && !rst_i;
    mac_sample_o   = mac_valid_o ? ram_dob_i : '0;
    mac_tap_o      = rst_i ? '0 : mac_tap_q;
    mac_first_o    = mac_first_q && mac_valid_o;
    mac_last_o     = mac_last_q && mac_valid_o;
  end

endmodule : student_sample_sequencer
`default_nettype wire

// File: tb/tb_student_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_student_sample_sequencer
// Description : Randomised scoreboard bench for student_sample_sequencer.
//               Two builds: AddrWidth=3/NumTaps=4 and AddrWidth=3/NumTaps=1,
//               each attached to a behavioural read-first 1-cycle DPRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_student_sample_sequencer;

  localparam int AW    = 3;
  localparam int DS    = 16;
  localparam int NT0   = 4;
  localparam int NT1   = 1;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic [DS-1:0] s;
    logic [AW-1:0] t;
    logic          f;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- DUT 0
  logic          rst0 = 1'b1;
  logic [DS-1:0] s0_data = '0;
  logic          s0_valid = 1'b0;
  logic          d0_ready, d0_ena, d0_wea, d0_enb, d0_mv, d0_mf, d0_ml, d0_busy;
  logic [AW-1:0] d0_addra, d0_addrb, d0_mt;
  logic [DS-1:0] d0_dia, d0_dob, d0_ms;

  student_sample_sequencer #(.AddrWidth(AW), .DataSize(DS), .NumTaps(NT0)) u_dut0 (
    .clk_i(clk), .rst_i(rst0),
    .sample_i(s0_data), .sample_valid_i(s0_valid), .sample_ready_o(d0_ready),
    .ram_ena_o(d0_ena), .ram_wea_o(d0_wea), .ram_addra_o(d0_addra), .ram_dia_o(d0_dia),
    .ram_enb_o(d0_enb), .ram_addrb_o(d0_addrb), .ram_dob_i(d0_dob),
    .mac_valid_o(d0_mv), .mac_sample_o(d0_ms), .mac_tap_o(d0_mt),
    .mac_first_o(d0_mf), .mac_last_o(d0_ml), .busy_o(d0_busy)
  );

  // ---------------------------------------------------------------- DUT 1
  logic          rst1 = 1'b1;
  logic [DS-1:0] s1_data = '0;
  logic          s1_valid = 1'b0;
  logic          d1_ready, d1_ena, d1_wea, d1_enb, d1_mv, d1_mf, d1_ml, d1_busy;
  logic [AW-1:0] d1_addra, d1_addrb, d1_mt;
  logic [DS-1:0] d1_dia, d1_dob, d1_ms;

  student_sample_sequencer #(.AddrWidth(AW), .DataSize(DS), .NumTaps(NT1)) u_dut1 (
    .clk_i(clk), .rst_i(rst1),
    .sample_i(s1_data), .sample_valid_i(s1_valid), .sample_ready_o(d1_ready),
    .ram_ena_o(d1_ena), .ram_wea_o(d1_wea), .ram_addra_o(d1_addra), .ram_dia_o(d1_dia),
    .ram_enb_o(d1_enb), .ram_addrb_o(d1_addrb), .ram_dob_i(d1_dob),
    .mac_valid_o(d1_mv), .mac_sample_o(d1_ms), .mac_tap_o(d1_mt),
    .mac_first_o(d1_mf), .mac_last_o(d1_ml), .busy_o(d1_busy)
  );

  // ------------------------------------- behavioural read-first DPRAMs
  logic [DS-1:0] ram0 [DEPTH];
  logic [DS-1:0] ram1 [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram0[i] = '0;
      ram1[i] = '0;
    end
    d0_dob = '0;
    d1_dob = '0;
  end
  always @(posedge clk) begin
    if (d0_ena && d0_wea) ram0[d0_addra] <= d0_dia;
    if (d0_enb)           d0_dob <= ram0[d0_addrb];
    if (d1_ena && d1_wea) ram1[d1_addra] <= d1_dia;
    if (d1_enb)           d1_dob <= ram1[d1_addrb];
  end

  // -------------------------------------------------- reference models
  // Sample history as a circular buffer; a sample's burst reads the most
  // recent NumTaps entries, newest first. Memory survives reset.
  logic [DS-1:0] ref0 [DEPTH];
  logic [DS-1:0] ref1 [DEPTH];
  int            wp0 = 0;
  int            wp1 = 0;
  beat_t         q0[$];
  beat_t         q1[$];
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ref0[i] = '0;
      ref1[i] = '0;
    end
  end

  function automatic beat_t mk_beat(input logic [DS-1:0] s, input int t, input int nt);
    beat_t b;
    b.s = s;
    b.t = AW'(t);
    b.f = (t == 0);
    b.l = (t == nt - 1);
    return b;
  endfunction

  // ------------------------------------------------------------ drivers
  // Holds valid for n samples in a row; consecutive accepts within a burst
  // must be exactly NumTaps+2 cycles apart.
  task automatic burst0(input int n, input bit rnd, input logic [DS-1:0] base_val);
    int last_acc = 0;
    for (int k = 0; k < n; k++) begin
      bit got = 0;
      s0_data  = rnd ? DS'($urandom) : base_val + DS'(k);
      s0_valid = 1'b1;
      for (int w = 0; w < 100 && !got; w++) begin
        @(negedge clk);
        if (d0_ready) got = 1;
      end
      if (!got) begin
        n_cmp++; n_err++;
        $display("FAIL d0_accept_timeout: ready never seen, required within 100 cycles");
        s0_valid = 1'b0;
        return;
      end
      check("d0_write_addr", d0_addra, wp0);
      check("d0_write_data", d0_dia, s0_data);
      if (k > 0) check("d0_interval", cyc - last_acc, NT0 + 2);
      last_acc = cyc;
      ref0[wp0] = s0_data;
      for (int t = 0; t < NT0; t++) q0.push_back(mk_beat(ref0[(wp0 - t) & (DEPTH - 1)], t, NT0));
      wp0 = (wp0 + 1) & (DEPTH - 1);
      @(posedge clk); #1;
    end
    s0_valid = 1'b0;
  endtask

  task automatic burst1(input int n);
    int last_acc = 0;
    for (int k = 0; k < n; k++) begin
      bit got = 0;
      s1_data  = DS'($urandom);
      s1_valid = 1'b1;
      for (int w = 0; w < 100 && !got; w++) begin
        @(negedge clk);
        if (d1_ready) got = 1;
      end
      if (!got) begin
        n_cmp++; n_err++;
        $display("FAIL d1_accept_timeout: ready never seen, required within 100 cycles");
        s1_valid = 1'b0;
        return;
      end
      check("d1_write_addr", d1_addra, wp1);
      if (k > 0) check("d1_interval", cyc - last_acc, NT1 + 2);
      last_acc = cyc;
      ref1[wp1] = s1_data;
      q1.push_back(mk_beat(s1_data, 0, NT1));
      wp1 = (wp1 + 1) & (DEPTH - 1);
      @(posedge clk); #1;
    end
    s1_valid = 1'b0;
  endtask

  task automatic reset0(input int n);
    rst0 = 1'b1;
    q0.delete();
    wp0 = 0;
    repeat (n) begin @(posedge clk); #1; end
    rst0 = 1'b0;
  endtask

  // ----------------------------------------------------------- monitors
  beat_t e0, e1;
  always @(negedge clk) begin
    if (!rst0) begin
      if (d0_mv) begin
        if (q0.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL d0_unexpected_beat: got tap %0d, required no beat", d0_mt);
        end else begin
          e0 = q0.pop_front();
          check("d0_beat", {d0_ms, d0_mt, d0_mf, d0_ml}, e0);
        end
      end else begin
        check("d0_flags_idle", {d0_mf, d0_ml}, 2'b00);
      end
      check("d0_wr_only_on_accept", {d0_ena, d0_wea}, {2{s0_valid && d0_ready}});
      check("d0_ready_vs_busy", d0_ready, !d0_busy);
    end
  end

  always @(negedge clk) begin
    if (!rst1) begin
      if (d1_mv) begin
        if (q1.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL d1_unexpected_beat: got tap %0d, required no beat", d1_mt);
        end else begin
          e1 = q1.pop_front();
          check("d1_beat", {d1_ms, d1_mt, d1_mf, d1_ml}, e1);
        end
      end
      check("d1_wr_only_on_accept", {d1_ena, d1_wea}, {2{s1_valid && d1_ready}});
    end
  end

  // ------------------------------------------------------------ sequence
  initial begin
    // Reset values while reset is held
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs",
          {d0_mv, d0_mf, d0_ml, d0_busy, d0_ena, d0_wea, d0_enb, d0_ready},
          8'h00);
    check("rst_mac_data", {d0_ms, d0_mt}, '0);
    check("rst1_outputs", {d1_mv, d1_busy, d1_ready, d1_ena, d1_enb}, 5'h00);
    @(posedge clk); #1;
    rst0 = 1'b0;

    // Single sample into an all-zero memory
    burst0(1, 1'b0, 16'h0011);
    repeat (8) begin @(posedge clk); #1; end

    // Nine back-to-back samples from a fresh pointer; the ninth wraps to 0
    reset0(2);
    burst0(9, 1'b0, 16'd1);
    repeat (8) begin @(posedge clk); #1; end

    // Abort a burst with reset on its second READ cycle
    burst0(1, 1'b0, 16'hABCD);
    @(posedge clk); #1;
    rst0 = 1'b1;
    q0.delete();
    wp0 = 0;
    @(negedge clk);
    check("abort_rst_quiet", {d0_busy, d0_mv, d0_ready, d0_enb}, 4'h0);
    @(posedge clk); #1;
    rst0 = 1'b0;
    @(negedge clk);
    check("abort_no_beat_after", {d0_mv, d0_busy}, 2'b00);
    @(posedge clk); #1;
    burst0(2, 1'b1, '0);
    repeat (8) begin @(posedge clk); #1; end

    // Randomised bursts and gaps
    for (int r = 0; r < 25; r++) begin
      burst0($urandom_range(1, 3), 1'b1, '0);
      repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
    end

    // Single-tap build
    rst1 = 1'b0;
    burst1(6);
    repeat (3) begin @(posedge clk); #1; end
    burst1(4);

    repeat (12) begin @(posedge clk); #1; end
    check("d0_all_beats_seen", q0.size(), 0);
    check("d1_all_beats_seen", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

endmodule : tb_student_sample_sequencer
`default_nettype wire

// File: doc/student_sample_sequencer.md
STUDENT_SAMPLE_SEQUENCER -- requirements
Module: student_sample_sequencer

Interface
REQ-001 SHALL have parameter AddrWidth, default 10, sample-memory address width.
REQ-002 SHALL have parameter DataSize, default 16, sample width in bits.
REQ-003 SHALL have parameter NumTaps, default 1024, taps read per input sample; legal range 1..2**AddrWidth.
REQ-004 SHALL have port clk_i, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have ports sample_i (input, DataSize, new sample), sample_valid_i (input, 1) and sample_ready_o (output, 1) as a valid/ready input handshake.
REQ-007 SHALL have outputs ram_ena_o (1), ram_wea_o (1), ram_addra_o (AddrWidth) and ram_dia_o (DataSize), driving the sample DPRAM write port.
REQ-008 SHALL have outputs ram_enb_o (1) and ram_addrb_o (AddrWidth) and input ram_dob_i (DataSize), driving the sample DPRAM read port, which has 1-cycle read latency.
REQ-009 SHALL have outputs mac_valid_o (1), mac_sample_o (DataSize), mac_tap_o (AddrWidth), mac_first_o (1) and mac_last_o (1) as the stream to the MAC stage.
REQ-010 SHALL have output busy_o, 1 bit, high whenever the state is not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, READ and DRAIN.
REQ-012 In IDLE: sample_ready_o=1; on sample_valid_i&&sample_ready_o, assert ram_ena_o=ram_wea_o=1 with ram_addra_o=wr_ptr and ram_dia_o=sample_i in that same cycle, latch base=wr_ptr, clear tap=0, go to READ.
REQ-013 sample_ready_o SHALL be 0 in READ and DRAIN; a held sample_valid_i is accepted only after return to IDLE.
REQ-014 In READ, every cycle: ram_enb_o=1, ram_addrb_o=(base-tap) mod 2**AddrWidth, so tap 0 is the newest sample; tap increments; after tap==NumTaps-1 is issued, go to DRAIN.
REQ-015 DRAIN SHALL last exactly one cycle; in it wr_ptr increments mod 2**AddrWidth (2**AddrWidth-1 wraps to 0); then go to IDLE.
REQ-016 mac_valid_o SHALL be asserted exactly one cycle after each read issue, with mac_sample_o=ram_dob_i and mac_tap_o equal to the tap of that issue.
REQ-017 mac_first_o SHALL be high only with tap 0 and mac_last_o only with tap NumTaps-1; both are qualified by mac_valid_o; both are high together when NumTaps=1.
REQ-018 Throughput SHALL be one sample per NumTaps+2 cycles; back-to-back valid SHALL yield IDLE for one cycle only.
REQ-019 The write to a given address and the first read of that address SHALL never occur in the same cycle; the read-first RAM therefore always returns the newly written sample for tap 0.
REQ-020 Outside the cases in REQ-012 and REQ-014, ram_ena_o, ram_wea_o and ram_enb_o SHALL be 0. Addresses and data are don't-care but SHALL be driven by registers or constants, never X.

Reset
REQ-021 While rst_i=1 the block SHALL go to IDLE and set wr_ptr=0, base=0 and tap=0.
REQ-022 While rst_i=1 it SHALL drive mac_valid_o=0, mac_first_o=0, mac_last_o=0, mac_sample_o=0, mac_tap_o=0, busy_o=0, all ram enables 0, and sample_ready_o=0.
REQ-023 Reset asserted mid-READ SHALL abort the burst: no mac_valid_o in the cycle after reset is sampled, and no partial wr_ptr advance.
REQ-024 Memory contents SHALL NOT be cleared by reset; stale samples remain readable.

Structure
REQ-025 The FSM state enum (IDLE/READ/DRAIN) SHALL be defined in shared package student_fir_pkg, alongside the default AddrWidth and DataSize constants.
REQ-026 No sub-module SHALL be instantiated; the DPRAM (student_dpram_samples) is instantiated by the parent alongside this block.
REQ-027 The tap/read-issue pipeline register SHALL be a single stage, matching the 1-cycle RAM latency.

Verification (AddrWidth=3, NumTaps=4, behavioural read-first RAM with 1-cycle latency)
REQ-028 Reset, then sample 0x0011 -> write at addr 0; reads at addrb 0,7,6,5; mac_tap 0..3 with first on tap 0 and last on tap 3; mac_sample sequence 0x0011,0,0,0 (zero-initialised RAM).
REQ-029 Samples 1..9 held valid back-to-back -> each accepted every 6 cycles; the 9th write lands at addr 0 (wrap). Its reads return samples 9,8,7,6.
REQ-030 sample_valid_i held high during READ -> sample_ready_o=0 and no write occurs until IDLE; the sample is then accepted exactly once.
REQ-031 rst_i pulsed on the 2nd READ cycle -> mac_valid_o=0 from the next cycle; the next sample writes to addr 0 and busy_o=0 during reset.
REQ-032 NumTaps=1 build -> a single read per sample with mac_first_o=mac_last_o=1, and throughput of 3 cycles per sample.
